wall_follower_robot_p: RTL and testbench

- Parametrised successor to the single-cycle Moore wall-following robot.
- Adds the following, all as Moore outputs decoded from registered state:
  - multi-cycle rotations;
  - selectable wall side (left or right);
  - a 2-bit heading tracker;
  - a stuck detector that halts the robot after too many rotations in a row.
- Sits between the sensor inputs (head, wall) and the motor command outputs (front, rotate, rot_cw).

---
 rtl/wall_follower_robot_p.sv | 187 ++++++++++++++++++
 tb/tb_wall_follower_robot_p.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wall_follower_robot_p.sv
// Wall-following robot controller with multi-cycle rotations, selectable
// wall side, heading tracking and a stuck detector. Moore outputs only:
// every motor/status output is a flop decoded from the next registered state.
module wall_follower_robot_p #(
    parameter int unsigned ROT_CYCLES  = 1,
    parameter int unsigned STUCK_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       side_sel,
    input  logic       head,
    input  logic       wall,
    input  logic       clear,
    output logic       front,
    output logic       rotate,
    output logic       rot_cw,
    output logic [1:0] heading,
    output logic       stuck
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned HDG_W = 2;

    localparam logic [CNT_W-1:0] ROT_LAST  = CNT_W'(ROT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STUCK_MAX = CNT_W'(STUCK_LIMIT);

    typedef enum logic [2:0] {
        SEEK       = 3'd0,
        FOLLOW     = 3'd1,
        ROT_AWAY   = 3'd2,
        ROT_TOWARD = 3'd3,
        GAP        = 3'd4,
        HALT       = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               side;
    logic               side_nxt;
    logic [CNT_W-1:0]   rot_cnt;
    logic [CNT_W-1:0]   rot_cnt_nxt;
    logic [CNT_W-1:0]   stuck_cnt;
    logic [CNT_W-1:0]   stuck_cnt_nxt;
    logic [HDG_W-1:0]   heading_nxt;

    logic               rot_done;
    logic               turn_cw;
    logic               limit_hit;
    logic               front_nxt;
    logic               rotate_nxt;
    logic               rot_cw_nxt;
    logic               stuck_nxt;

    // Direction of the rotation in progress: away is clockwise for the left wall.
    assign turn_cw   = (state == ROT_AWAY) ? ~side : side;
    assign rot_done  = (rot_cnt == ROT_LAST);
    assign limit_hit = ((stuck_cnt + CNT_W'(1)) == STUCK_MAX);

    // Next-state, counter and heading update for one enabled edge.
    always_comb begin
        state_nxt     = state;
        side_nxt      = side;
        rot_cnt_nxt   = rot_cnt;
        stuck_cnt_nxt = stuck_cnt;
        heading_nxt   = heading;

        if (state == SEEK) begin
            side_nxt = side_sel;
        end

        case (state)
            SEEK: begin
                stuck_cnt_nxt = '0;
                if (head) begin
                    state_nxt = ROT_AWAY;
                end else if (wall) begin
                    state_nxt = FOLLOW;
                end
            end

            FOLLOW: begin
                stuck_cnt_nxt = '0;
                if (head) begin
                    state_nxt = ROT_AWAY;
                end else if (!wall) begin
                    state_nxt = ROT_TOWARD;
                end
            end

            GAP: begin
                stuck_cnt_nxt = '0;
                if (head) begin
                    state_nxt = ROT_AWAY;
                end else if (wall) begin
                    state_nxt = FOLLOW;
                end else begin
                    state_nxt = ROT_TOWARD;
                end
            end

            ROT_AWAY, ROT_TOWARD: begin
                if (rot_done) begin
                    rot_cnt_nxt = '0;
                    heading_nxt = turn_cw ? (heading + HDG_W'(1))
                                          : (heading - HDG_W'(1));
                    if (stuck_cnt != STUCK_MAX) begin
                        stuck_cnt_nxt = stuck_cnt + CNT_W'(1);
                    end
                    if (limit_hit) begin
                        state_nxt = HALT;
                    end else if (state == ROT_AWAY) begin
                        state_nxt = head ? ROT_AWAY : FOLLOW;
                    end else begin
                        state_nxt = GAP;
                    end
                end else begin
                    rot_cnt_nxt = rot_cnt + CNT_W'(1);
                end
            end

            HALT: begin
                if (clear) begin
                    state_nxt     = SEEK;
                    stuck_cnt_nxt = '0;
                end
            end

            default: begin
                state_nxt     = SEEK;
                rot_cnt_nxt   = '0;
                stuck_cnt_nxt = '0;
            end
        endcase
    end

    // Moore decode of the state that will be held after the edge.
    always_comb begin
        front_nxt  = 1'b0;
        rotate_nxt = 1'b0;
        rot_cw_nxt = 1'b0;
        stuck_nxt  = 1'b0;
        case (state_nxt)
            SEEK, FOLLOW, GAP: front_nxt = 1'b1;
            ROT_AWAY: begin
                rotate_nxt = 1'b1;
                rot_cw_nxt = ~side_nxt;
            end
            ROT_TOWARD: begin
                rotate_nxt = 1'b1;
                rot_cw_nxt = side_nxt;
            end
            HALT:    stuck_nxt = 1'b1;
            default: front_nxt = 1'b0;
        endcase
    end

    // State, counters, heading and registered outputs; en=0 freezes and idles motors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEEK;
            side      <= 1'b0;
            rot_cnt   <= '0;
            stuck_cnt <= '0;
            heading   <= '0;
            front     <= 1'b1;
            rotate    <= 1'b0;
            rot_cw    <= 1'b0;
            stuck     <= 1'b0;
        end else if (en) begin
            state     <= state_nxt;
            side      <= side_nxt;
            rot_cnt   <= rot_cnt_nxt;
            stuck_cnt <= stuck_cnt_nxt;
            heading   <= heading_nxt;
            front     <= front_nxt;
            rotate    <= rotate_nxt;
            rot_cw    <= rot_cw_nxt;
            stuck     <= stuck_nxt;
        end else begin
            front     <= 1'b0;
            rotate    <= 1'b0;
            rot_cw    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wall_follower_robot_p.sv
// Bench for wall_follower_robot_p: three parameterisations driven in lockstep,
// each compared every cycle against a behavioural model of the robot.
module tb_wall_follower_robot_p;

    localparam int NI = 3;
    localparam int ROT_T [NI] = '{3, 1, 1};
    localparam int LIM_T [NI] = '{4, 4, 1};

    localparam int M_SEEK   = 0;
    localparam int M_FOLLOW = 1;
    localparam int M_GAP    = 2;
    localparam int M_TURN   = 3;
    localparam int M_HALT   = 4;

    typedef struct {
        int mode;
        int dir;      // +1 clockwise, -1 counter-clockwise
        bit away;
        int left;     // rotate cycles still to go
        int side;
        int hdg;
        int streak;   // rotations since last forward cycle
        bit f;
        bit r;
        bit cw;
        bit st;
    } mdl_t;

    logic clk;
    logic reset;
    logic en;
    logic side_sel;
    logic head;
    logic wall;
    logic clear;

    logic [NI-1:0] front_v;
    logic [NI-1:0] rotate_v;
    logic [NI-1:0] rot_cw_v;
    logic [NI-1:0] stuck_v;
    logic [1:0]    hdg_v [NI];

    mdl_t m [NI];
    int   checks = 0;
    int   errors = 0;

    wall_follower_robot_p #(.ROT_CYCLES(3), .STUCK_LIMIT(4)) u_a (
        .clk(clk), .reset(reset), .en(en), .side_sel(side_sel), .head(head),
        .wall(wall), .clear(clear), .front(front_v[0]), .rotate(rotate_v[0]),
        .rot_cw(rot_cw_v[0]), .heading(hdg_v[0]), .stuck(stuck_v[0]));

    wall_follower_robot_p #(.ROT_CYCLES(1), .STUCK_LIMIT(4)) u_b (
        .clk(clk), .reset(reset), .en(en), .side_sel(side_sel), .head(head),
        .wall(wall), .clear(clear), .front(front_v[1]), .rotate(rotate_v[1]),
        .rot_cw(rot_cw_v[1]), .heading(hdg_v[1]), .stuck(stuck_v[1]));

    wall_follower_robot_p #(.ROT_CYCLES(1), .STUCK_LIMIT(1)) u_c (
        .clk(clk), .reset(reset), .en(en), .side_sel(side_sel), .head(head),
        .wall(wall), .clear(clear), .front(front_v[2]), .rotate(rotate_v[2]),
        .rot_cw(rot_cw_v[2]), .heading(hdg_v[2]), .stuck(stuck_v[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic mdl_t mdl_reset();
        mdl_t n;
        n = '{default: 0};
        n.mode = M_SEEK;
        n.f    = 1'b1;
        return n;
    endfunction

    function automatic mdl_t begin_turn(mdl_t n, bit away, int rot);
        n.mode = M_TURN;
        n.away = away;
        n.dir  = ((n.side == 0) == away) ? 1 : -1;
        n.left = rot;
        return n;
    endfunction

    function automatic mdl_t mdl_step(mdl_t n, int rot, int lim, bit en_i,
                                      bit side_i, bit head_i, bit wall_i, bit clear_i);
        if (!en_i) begin
            n.f  = 1'b0;
            n.r  = 1'b0;
            n.cw = 1'b0;
            return n;
        end
        if (n.mode == M_SEEK) n.side = int'(side_i);
        case (n.mode)
            M_SEEK: begin
                n.streak = 0;
                if (head_i) n = begin_turn(n, 1'b1, rot);
                else if (wall_i) n.mode = M_FOLLOW;
            end
            M_FOLLOW: begin
                n.streak = 0;
                if (head_i) n = begin_turn(n, 1'b1, rot);
                else if (!wall_i) n = begin_turn(n, 1'b0, rot);
            end
            M_GAP: begin
                n.streak = 0;
                if (head_i) n = begin_turn(n, 1'b1, rot);
                else if (wall_i) n.mode = M_FOLLOW;
                else n = begin_turn(n, 1'b0, rot);
            end
            M_TURN: begin
                n.left = n.left - 1;
                if (n.left == 0) begin
                    n.hdg    = (n.hdg + n.dir + 4) % 4;
                    n.streak = (n.streak < lim) ? n.streak + 1 : lim;
                    if (n.streak == lim) n.mode = M_HALT;
                    else if (n.away && head_i) n = begin_turn(n, 1'b1, rot);
                    else if (n.away) n.mode = M_FOLLOW;
                    else n.mode = M_GAP;
                end
            end
            default: begin
                if (clear_i) begin
                    n.mode   = M_SEEK;
                    n.streak = 0;
                end
            end
        endcase
        n.f  = (n.mode == M_SEEK) || (n.mode == M_FOLLOW) || (n.mode == M_GAP);
        n.r  = (n.mode == M_TURN);
        n.cw = (n.mode == M_TURN) && (n.dir > 0);
        n.st = (n.mode == M_HALT);
        return n;
    endfunction

    task automatic chk(string tag, logic [3:0] got, logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s/u%0d/front", tag, i), 4'(front_v[i]), 4'(m[i].f));
            chk($sformatf("%s/u%0d/rotate", tag, i), 4'(rotate_v[i]), 4'(m[i].r));
            chk($sformatf("%s/u%0d/rot_cw", tag, i), 4'(rot_cw_v[i]), 4'(m[i].cw));
            chk($sformatf("%s/u%0d/stuck", tag, i), 4'(stuck_v[i]), 4'(m[i].st));
            chk($sformatf("%s/u%0d/heading", tag, i), 4'(hdg_v[i]), 4'(m[i].hdg));
        end
    endtask

    // One clock edge: advance the models with the inputs the DUTs sample, then compare.
    task automatic step(string tag);
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            m[i] = mdl_step(m[i], ROT_T[i], LIM_T[i], en, side_sel, head, wall, clear);
        end
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset: outputs must take reset values without waiting for an edge.
    task automatic do_reset(string tag);
        reset = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) m[i] = mdl_reset();
        check_all(tag);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        en       = 1'b1;
        side_sel = 1'b0;
        head     = 1'b0;
        wall     = 1'b0;
        clear    = 1'b0;
        for (int i = 0; i < NI; i++) m[i] = mdl_reset();

        // Reset and idle seeking
        do_reset("reset0");
        repeat (3) step("idle");

        // Left side: obstacle ahead from FOLLOW rotates clockwise
        wall = 1'b1;
        step("to_follow");
        head = 1'b1;
        step("head_pulse");
        head = 1'b0;
        repeat (6) step("rot_away_cw");

        // Right side: losing the wall turns toward it (clockwise), GAP, wrap heading
        do_reset("reset1");
        side_sel = 1'b1;
        wall     = 1'b1;
        step("follow_right");
        wall = 1'b0;
        repeat (22) step("toward_loop");
        wall = 1'b1;
        repeat (3) step("refollow");

        // Stuck detector and clear
        do_reset("reset2");
        side_sel = 1'b0;
        wall     = 1'b0;
        head     = 1'b1;
        repeat (14) step("stuck");
        head = 1'b0;
        step("halted_idle");
        clear = 1'b1;
        step("clear");
        clear = 1'b0;
        repeat (2) step("after_clear");

        // en=0 in the middle of a rotation, then reset mid-rotation
        do_reset("reset3");
        head = 1'b1;
        step("start_rot");
        head = 1'b0;
        step("rot_mid");
        en = 1'b0;
        repeat (2) step("en_low");
        en = 1'b1;
        repeat (4) step("resume");
        head = 1'b1;
        step("rot_again");
        head = 1'b0;
        step("rot_again2");
        do_reset("reset_mid_rot");
        step("post_reset");

        // side_sel changes outside SEEK are ignored
        do_reset("reset4");
        side_sel = 1'b0;
        wall     = 1'b1;
        step("follow_left");
        side_sel = 1'b1;
        repeat (2) step("side_flip_follow");
        head = 1'b1;
        step("head_latched_side");
        head = 1'b0;
        repeat (4) step("rot_latched_side");
        wall = 1'b0;
        repeat (5) step("toward_latched_side");

        // Randomised traffic
        for (int k = 0; k < 1200; k++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset("rand_reset");
            end
            en       = ($urandom_range(0, 9) != 0);
            head     = ($urandom_range(0, 2) == 0);
            wall     = 1'($urandom_range(0, 1));
            clear    = ($urandom_range(0, 4) == 0);
            side_sel = 1'($urandom_range(0, 1));
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
